// File: rtl/fifo_tx_credit_pkg.sv
// Shared SpaceWire constants for the transmit buffer: N-Char format, FIFO sizing
// and flow-control credit limits.
package fifo_tx_credit_pkg;
  localparam int DWIDTH     = 9;
  localparam int AWIDTH     = 6;
  localparam int DEPTH      = 2 ** AWIDTH;
  localparam int MAX_CREDIT = 56;
  localparam int FCT_GRANT  = 8;

  typedef logic [DWIDTH-1:0] nchar_t;

  // Bit 8 set marks a control N-Char
  localparam nchar_t NCHAR_EOP = 9'h100;
  localparam nchar_t NCHAR_EEP = 9'h101;
endpackage

// File: rtl/fifo_tx_credit_if.sv
// Host write port, encoder handshake, FCT input and status of the TX buffer.
interface fifo_tx_credit_if;
  import fifo_tx_credit_pkg::*;

  logic              link_run;
  logic              wr_en;
  nchar_t            data_in;
  logic              fct_in;
  logic              tx_ready;
  logic              tx_valid;
  nchar_t            tx_data;
  logic              f_full;
  logic              f_empty;
  logic [AWIDTH:0]   counter;
  logic [AWIDTH-1:0] credit;
  logic              credit_error;

  modport slave (
    input  link_run, wr_en, data_in, fct_in, tx_ready,
    output tx_valid, tx_data, f_full, f_empty, counter, credit, credit_error
  );

  modport master (
    output link_run, wr_en, data_in, fct_in, tx_ready,
    input  tx_valid, tx_data, f_full, f_empty, counter, credit, credit_error
  );
endinterface

// File: rtl/fifo_tx_credit_counter.sv
// TX flow-control credit: +FCT_GRANT per FCT, -1 per sent N-Char, with a sticky
// overflow flag when an FCT would exceed the credit ceiling.
module tx_credit_counter
  import fifo_tx_credit_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              i_link_run,
  input  logic              i_fct,
  input  logic              i_xfer,
  output logic [AWIDTH-1:0] o_credit,
  output logic              o_credit_error
);

  localparam logic [AWIDTH:0] L_GRANT = (AWIDTH+1)'(FCT_GRANT);
  localparam logic [AWIDTH:0] L_MAX   = (AWIDTH+1)'(MAX_CREDIT);

  logic [AWIDTH-1:0] r_credit;
  logic              r_error;
  logic [AWIDTH:0]   w_next;
  logic              w_over;
  logic [AWIDTH-1:0] w_dec;

  // One bit of headroom so an overflowing grant is detectable before truncation
  assign w_next = {1'b0, r_credit} - {{AWIDTH{1'b0}}, i_xfer} + (i_fct ? L_GRANT : '0);
  assign w_over = i_fct && (w_next > L_MAX);
  assign w_dec  = r_credit - {{(AWIDTH-1){1'b0}}, i_xfer};

  always_ff @(posedge clock) begin
    if (reset || !i_link_run) begin
      r_credit <= '0;
      r_error  <= 1'b0;
    end else if (w_over) begin
      r_credit <= w_dec;
      r_error  <= 1'b1;
    end else begin
      r_credit <= w_next[AWIDTH-1:0];
    end
  end

  assign o_credit       = r_credit;
  assign o_credit_error = r_error;

endmodule

// File: rtl/fifo_tx_credit.sv
// 64-entry first-word-fall-through N-Char FIFO whose output is released to the
// encoder only while the link runs and the far end has granted credit.
module fifo_tx_credit
  import fifo_tx_credit_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  fifo_tx_credit_if.slave bus
);

  localparam logic [AWIDTH:0] L_DEPTH = (AWIDTH+1)'(DEPTH);

  nchar_t            r_mem [DEPTH];
  logic [AWIDTH-1:0] r_wr_ptr;
  logic [AWIDTH-1:0] r_rd_ptr;
  logic [AWIDTH:0]   r_count;
  logic              r_full;
  logic              r_empty;

  logic              w_wr;
  logic              w_xfer;
  logic              w_tx_valid;
  logic [AWIDTH:0]   w_count_next;
  logic [AWIDTH-1:0] w_credit;
  logic              w_credit_error;

  assign w_wr       = bus.wr_en && !r_full;
  assign w_tx_valid = !r_empty && (w_credit != '0) && bus.link_run;
  assign w_xfer     = w_tx_valid && bus.tx_ready;

  always_comb begin
    w_count_next = r_count;
    case ({w_wr, w_xfer})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  // Storage is intentionally not reset
  always_ff @(posedge clock) begin
    if (w_wr) r_mem[r_wr_ptr] <= bus.data_in;
  end

  // Flags come from the next count so they track occupancy without lag
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_wr)   r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_xfer) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_next;
      r_full  <= (w_count_next == L_DEPTH);
      r_empty <= (w_count_next == '0);
    end
  end

  tx_credit_counter u_credit (
    .clock          (clock),
    .reset          (reset),
    .i_link_run     (bus.link_run),
    .i_fct          (bus.fct_in),
    .i_xfer         (w_xfer),
    .o_credit       (w_credit),
    .o_credit_error (w_credit_error)
  );

  assign bus.tx_valid     = w_tx_valid;
  assign bus.tx_data      = r_mem[r_rd_ptr];
  assign bus.f_full       = r_full;
  assign bus.f_empty      = r_empty;
  assign bus.counter      = r_count;
  assign bus.credit       = w_credit;
  assign bus.credit_error = w_credit_error;

endmodule

// File: tb/tb_fifo_tx_credit.sv
// Directed bench for fifo_tx_credit: credit grant/ceiling, draining, full/wrap,
// stall, simultaneous events and link_run clearing.
module tb_fifo_tx_credit;
  import fifo_tx_credit_pkg::*;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;

  fifo_tx_credit_if bus ();

  fifo_tx_credit dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write(input logic [8:0] d);
    bus.wr_en   = 1'b1;
    bus.data_in = d;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic fct(input int n);
    bus.fct_in = 1'b1;
    repeat (n) tick();
    bus.fct_in = 1'b0;
  endtask

  task automatic link_clear();
    bus.link_run = 1'b0;
    tick();
    bus.link_run = 1'b1;
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    reset        = 1'b1;
    bus.link_run = 1'b0;
    bus.wr_en    = 1'b0;
    bus.data_in  = '0;
    bus.fct_in   = 1'b0;
    bus.tx_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    chk("rst_counter", 32'(bus.counter), 0);
    chk("rst_empty", 32'(bus.f_empty), 1);
    chk("rst_full", 32'(bus.f_full), 0);
    chk("rst_credit", 32'(bus.credit), 0);
    chk("rst_err", 32'(bus.credit_error), 0);
    chk("rst_valid", 32'(bus.tx_valid), 0);

    // Credit accumulation and ceiling
    bus.link_run = 1'b1;
    fct(3);
    chk("fct3_credit", 32'(bus.credit), 24);
    chk("fct3_err", 32'(bus.credit_error), 0);
    fct(4);
    chk("fct7_credit", 32'(bus.credit), 56);
    chk("fct7_err", 32'(bus.credit_error), 0);
    fct(1);
    chk("fct8_credit", 32'(bus.credit), 56);
    chk("fct8_err", 32'(bus.credit_error), 1);
    link_clear();
    chk("clr_credit", 32'(bus.credit), 0);
    chk("clr_err", 32'(bus.credit_error), 0);

    // Credit 8, ten chars: exactly eight go out back to back
    fct(1);
    chk("c8_credit", 32'(bus.credit), 8);
    for (int i = 0; i < 10; i++) write(9'(32'h10 + i));
    chk("c8_counter", 32'(bus.counter), 10);
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("c8_valid%0d", i), 32'(bus.tx_valid), 1);
      chk($sformatf("c8_data%0d", i), 32'(bus.tx_data), 32'h10 + i);
      tick();
    end
    chk("c8_valid_end", 32'(bus.tx_valid), 0);
    chk("c8_credit_end", 32'(bus.credit), 0);
    chk("c8_counter_end", 32'(bus.counter), 2);
    bus.tx_ready = 1'b0;
    chk("c8_head", 32'(bus.tx_data), 32'h18);

    // Empty the two leftovers, then clear the remaining credit
    fct(1);
    bus.tx_ready = 1'b1;
    tick();
    tick();
    bus.tx_ready = 1'b0;
    chk("left_empty", 32'(bus.f_empty), 1);
    chk("left_credit", 32'(bus.credit), 6);
    link_clear();
    chk("left_clr", 32'(bus.credit), 0);

    // Fill to 64 with no credit, drop the 65th, then drain across the pointer wrap
    for (int i = 0; i < 64; i++) write(9'(i));
    chk("full_flag", 32'(bus.f_full), 1);
    chk("full_counter", 32'(bus.counter), 64);
    chk("full_valid", 32'(bus.tx_valid), 0);
    write(9'h1AA);
    chk("drop_counter", 32'(bus.counter), 64);
    fct(7);
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 56; i++) begin
      chk($sformatf("dr_data%0d", i), 32'(bus.tx_data), i);
      tick();
    end
    bus.tx_ready = 1'b0;
    chk("dr_credit", 32'(bus.credit), 0);
    chk("dr_counter", 32'(bus.counter), 8);
    chk("dr_full", 32'(bus.f_full), 0);
    fct(1);
    bus.tx_ready = 1'b1;
    for (int i = 56; i < 64; i++) begin
      chk($sformatf("dr_data%0d", i), 32'(bus.tx_data), i);
      tick();
    end
    bus.tx_ready = 1'b0;
    chk("dr_empty", 32'(bus.f_empty), 1);
    chk("dr_counter_end", 32'(bus.counter), 0);
    chk("dr_valid_end", 32'(bus.tx_valid), 0);

    // Stall: valid held with ready low keeps data and credit
    write(9'h0A0);
    write(9'h0A1);
    write(9'h0A2);
    fct(1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("st_valid%0d", i), 32'(bus.tx_valid), 1);
      chk($sformatf("st_data%0d", i), 32'(bus.tx_data), 32'hA0);
      chk($sformatf("st_credit%0d", i), 32'(bus.credit), 8);
    end
    bus.tx_ready = 1'b1;
    tick();
    bus.tx_ready = 1'b0;
    chk("st_credit_after", 32'(bus.credit), 7);
    chk("st_counter_after", 32'(bus.counter), 2);
    chk("st_data_after", 32'(bus.tx_data), 32'hA1);

    // Queue A1,A2,A3,A4; send two -> credit 5, head A3
    write(9'h0A3);
    write(9'h0A4);
    bus.tx_ready = 1'b1;
    tick();
    tick();
    bus.tx_ready = 1'b0;
    chk("sim_credit5", 32'(bus.credit), 5);
    chk("sim_head", 32'(bus.tx_data), 32'hA3);
    bus.fct_in   = 1'b1;
    bus.tx_ready = 1'b1;
    tick();
    bus.fct_in   = 1'b0;
    bus.tx_ready = 1'b0;
    chk("fct_xfer_credit", 32'(bus.credit), 12);
    chk("fct_xfer_counter", 32'(bus.counter), 1);
    write(9'h0B0);
    write(9'h0B1);
    chk("wr_xfer_pre", 32'(bus.counter), 3);
    bus.wr_en    = 1'b1;
    bus.data_in  = 9'h0B2;
    bus.tx_ready = 1'b1;
    tick();
    bus.wr_en    = 1'b0;
    bus.tx_ready = 1'b0;
    chk("wr_xfer_counter", 32'(bus.counter), 3);
    chk("wr_xfer_credit", 32'(bus.credit), 11);
    chk("wr_xfer_head", 32'(bus.tx_data), 32'hB0);

    // Sticky error at credit 16, then link_run drop (with a coincident FCT)
    link_clear();
    fct(8);
    chk("err_set", 32'(bus.credit_error), 1);
    for (int i = 0; i < 42; i++) write(9'(i));
    chk("err_counter", 32'(bus.counter), 45);
    bus.tx_ready = 1'b1;
    repeat (40) tick();
    bus.tx_ready = 1'b0;
    chk("err_credit16", 32'(bus.credit), 16);
    chk("err_hold", 32'(bus.credit_error), 1);
    chk("err_counter5", 32'(bus.counter), 5);
    chk("err_valid", 32'(bus.tx_valid), 1);
    bus.link_run = 1'b0;
    bus.fct_in   = 1'b1;
    #1;
    chk("down_valid_comb", 32'(bus.tx_valid), 0);
    tick();
    bus.fct_in = 1'b0;
    chk("down_credit", 32'(bus.credit), 0);
    chk("down_err", 32'(bus.credit_error), 0);
    chk("down_valid", 32'(bus.tx_valid), 0);
    chk("down_counter", 32'(bus.counter), 5);
    bus.link_run = 1'b1;
    tick();
    chk("up_credit", 32'(bus.credit), 0);
    chk("up_valid", 32'(bus.tx_valid), 0);

    // Synchronous reset mid-operation
    fct(1);
    bus.wr_en    = 1'b1;
    bus.tx_ready = 1'b1;
    bus.fct_in   = 1'b1;
    reset        = 1'b1;
    tick();
    bus.wr_en    = 1'b0;
    bus.tx_ready = 1'b0;
    bus.fct_in   = 1'b0;
    reset        = 1'b0;
    chk("mid_rst_counter", 32'(bus.counter), 0);
    chk("mid_rst_empty", 32'(bus.f_empty), 1);
    chk("mid_rst_credit", 32'(bus.credit), 0);
    chk("mid_rst_valid", 32'(bus.tx_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
